// File: rtl/nv_nvdla_pdp_rdrsp_pkg.sv
// Shared widths, engine states and request layout for the PDP RDMA read responder.
package nv_nvdla_pdp_rdrsp_pkg;
   localparam int RDREQ_PD_W   = 79;
   localparam int RDRSP_DATA_W = 512;
   localparam int RDRSP_MASK_W = 2;
   localparam int RDRSP_PD_W   = 514;
   localparam int ATOM_BYTES   = 32;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STREAM} rdrsp_state_t;

   typedef struct packed {
      logic [63:0] addr;
      logic [14:0] size;
   } rd_req_t;

   // One 32-byte atom is the 32-bit seed word repeated eight times.
   function automatic logic [RDRSP_DATA_W/2-1:0] atom_fill(input logic [31:0] w);
      return {8{w}};
   endfunction
endpackage

// File: rtl/nv_nvdla_pdp_rdrsp_req_fifo.sv
// Flop-based synchronous request FIFO; ready is simply "not full".
module nv_nvdla_pdp_rdrsp_req_fifo
   import nv_nvdla_pdp_rdrsp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  nvdla_core_clk,
   input  logic                  nvdla_core_rstn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [RDREQ_PD_W-1:0] in_pd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [RDREQ_PD_W-1:0] out_pd
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [RDREQ_PD_W-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         cnt;
   logic                  push, pop;

   assign in_ready  = (cnt != CW'(DEPTH));
   assign out_valid = (cnt != '0);
   assign out_pd    = mem[rd_ptr];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (push) mem[wr_ptr] <= in_pd;
   end
endmodule

// File: rtl/nv_nvdla_pdp_rdrsp.sv
// PDP RDMA read responder: address-derived data beats under latency-FIFO credit control.
// Optional NVDLA_PDP_RDRSP_PERF_EN adds a saturating response-stall counter output.
module nv_nvdla_pdp_rdrsp
   import nv_nvdla_pdp_rdrsp_pkg::*;
#(
   parameter int REQ_DEPTH   = 4,
   parameter int LAT_CREDITS = 32,
   parameter int RSP_LAT     = 4
) (
   input  logic                  nvdla_core_clk,
   input  logic                  nvdla_core_rstn,
   input  logic                  rd_req_valid,
   output logic                  rd_req_ready,
   input  logic [RDREQ_PD_W-1:0] rd_req_pd,
   output logic                  rd_rsp_valid,
   input  logic                  rd_rsp_ready,
   output logic [RDRSP_PD_W-1:0] rd_rsp_pd,
   input  logic                  rd_cdt_lat_fifo_pop,
`ifdef NVDLA_PDP_RDRSP_PERF_EN
   output logic [31:0]           rsp_stall_cnt,
`endif
   output logic                  cdt_err
);
   localparam int CDW = $clog2(LAT_CREDITS + 1);
   localparam int WCW = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;
   localparam logic [CDW-1:0] CDT_MAX = CDW'(LAT_CREDITS);

   rdrsp_state_t          state, state_nxt;
   logic                  fifo_valid, fifo_pop;
   logic [RDREQ_PD_W-1:0] fifo_pd;
   rd_req_t               req;
   logic [15:0]           n_atoms;
   logic [WCW-1:0]        wait_cnt;
   logic [31:0]           cur_addr;
   logic [14:0]           beat_left;
   logic                  odd_tail, last_beat, half_beat, rsp_hs;
   logic [CDW-1:0]        cdt;
   logic [RDRSP_PD_W-1:0] beat_pd;
   logic                  unused_addr_bits;

   nv_nvdla_pdp_rdrsp_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .in_valid        (rd_req_valid),
      .in_ready        (rd_req_ready),
      .in_pd           (rd_req_pd),
      .out_valid       (fifo_valid),
      .out_ready       (fifo_pop),
      .out_pd          (fifo_pd)
   );

   assign req              = '{addr: fifo_pd[63:0], size: fifo_pd[78:64]};
   assign n_atoms          = 16'(req.size) + 16'd1;
   assign unused_addr_bits = ^{req.addr[63:32], req.addr[4:0]};

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE:   if (fifo_valid) begin
                       fifo_pop  = 1'b1;
                       state_nxt = ST_WAIT;
                    end
         ST_WAIT:   if (wait_cnt == '0) state_nxt = ST_STREAM;
         ST_STREAM: if (rsp_hs && last_beat) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Beat index is implicit in cur_addr/beat_left, which only move on a handshake,
   // so the payload holds steady while the client stalls.
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         cur_addr  <= '0;
         beat_left <= '0;
         odd_tail  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: if (fifo_pop) begin
               wait_cnt  <= WCW'(RSP_LAT - 1);
               cur_addr  <= {req.addr[31:5], 5'b0};
               beat_left <= n_atoms[15:1] + 15'(n_atoms[0]);
               odd_tail  <= n_atoms[0];
            end
            ST_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - WCW'(1);
            ST_STREAM: if (rsp_hs) begin
               beat_left <= beat_left - 15'd1;
               cur_addr  <= cur_addr + 32'(2 * ATOM_BYTES);
            end
            default: ;
         endcase
      end
   end

   assign last_beat    = (beat_left == 15'd1);
   assign half_beat    = last_beat & odd_tail;
   assign rd_rsp_valid = (state == ST_STREAM) && (cdt != '0);
   assign rsp_hs       = rd_rsp_valid & rd_rsp_ready;
   assign beat_pd      = {half_beat ? 2'b01 : 2'b11,
                          half_beat ? {(RDRSP_DATA_W/2){1'b0}}
                                    : atom_fill(cur_addr + 32'(ATOM_BYTES)),
                          atom_fill(cur_addr)};
   assign rd_rsp_pd    = rd_rsp_valid ? beat_pd : '0;

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         cdt     <= CDT_MAX;
         cdt_err <= 1'b0;
      end else begin
         if (rd_cdt_lat_fifo_pop && (cdt == CDT_MAX)) cdt_err <= 1'b1;
         case ({rsp_hs, rd_cdt_lat_fifo_pop})
            2'b10:   cdt <= cdt - CDW'(1);
            2'b01:   if (cdt != CDT_MAX) cdt <= cdt + CDW'(1);
            default: ;
         endcase
      end
   end

`ifdef NVDLA_PDP_RDRSP_PERF_EN
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn)
         rsp_stall_cnt <= '0;
      else if ((state == ST_STREAM) && ((cdt == '0) || !rd_rsp_ready) && (rsp_stall_cnt != '1))
         rsp_stall_cnt <= rsp_stall_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_nv_nvdla_pdp_rdrsp.sv
// Directed scoreboard bench for nv_nvdla_pdp_rdrsp (default build).
module tb_nv_nvdla_pdp_rdrsp;
   import nv_nvdla_pdp_rdrsp_pkg::*;

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic                  rd_req_valid = 1'b0;
   logic                  rd_req_ready;
   logic [RDREQ_PD_W-1:0] rd_req_pd = '0;
   logic                  rd_rsp_valid;
   logic                  rd_rsp_ready = 1'b0;
   logic [RDRSP_PD_W-1:0] rd_rsp_pd;
   logic                  rd_cdt_lat_fifo_pop = 1'b0;
   logic                  cdt_err;

   int tests = 0;
   int fails = 0;
   int hs_cnt = 0;
   logic [RDRSP_PD_W-1:0] exp_q[$];
   logic                  prev_stall = 1'b0;
   logic [RDRSP_PD_W-1:0] prev_pd = '0;

   always #5 clk = ~clk;

   nv_nvdla_pdp_rdrsp #(.REQ_DEPTH(4), .LAT_CREDITS(32), .RSP_LAT(4)) dut (
      .nvdla_core_clk      (clk),
      .nvdla_core_rstn     (rstn),
      .rd_req_valid        (rd_req_valid),
      .rd_req_ready        (rd_req_ready),
      .rd_req_pd           (rd_req_pd),
      .rd_rsp_valid        (rd_rsp_valid),
      .rd_rsp_ready        (rd_rsp_ready),
      .rd_rsp_pd           (rd_rsp_pd),
      .rd_cdt_lat_fifo_pop (rd_cdt_lat_fifo_pop),
      .cdt_err             (cdt_err)
   );

   task automatic chk(input string tag, input logic [RDRSP_PD_W-1:0] obs, input logic [RDRSP_PD_W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RDRSP_PD_W-1:0] exp_beat(input logic [31:0] a, input int j, input int n);
      logic [31:0] w0;
      w0 = a + 32'(64 * j);
      if (2 * j + 1 < n) return {2'b11, {8{w0 + 32'd32}}, {8{w0}}};
      return {2'b01, 256'd0, {8{w0}}};
   endfunction

   task automatic push_exp(input logic [31:0] a, input int size);
      int n;
      n = size + 1;
      for (int j = 0; j < (n + 1) / 2; j++) exp_q.push_back(exp_beat(a, j, n));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rstn = 1'b1;
      hs_cnt = 0;
   endtask

   task automatic send_req(input logic [31:0] a, input int size);
      logic ok;
      ok = 1'b0;
      rd_req_pd = {15'(size), 32'h0, a};
      rd_req_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rd_req_ready) ok = 1'b1;
      end
      chk("req_accept", ok, 1);
      if (ok) push_exp(a, size);
      tick();
      rd_req_valid = 1'b0;
   endtask

   task automatic drain(input int max);
      for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
      chk("drain", exp_q.size(), 0);
   endtask

   // Response monitor: scoreboard compare on handshake, hold check while stalled.
   always @(negedge clk) begin
      if (rstn) begin
         if (prev_stall) begin
            chk("hold_valid", rd_rsp_valid, 1);
            chk("hold_pd", rd_rsp_pd, prev_pd);
         end
         if (rd_rsp_valid === 1'b1 && rd_rsp_ready) begin
            hs_cnt++;
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("beat_pd", rd_rsp_pd, exp_q.pop_front());
         end
         prev_stall = rd_rsp_valid & !rd_rsp_ready;
         prev_pd    = rd_rsp_pd;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      do_reset();
      chk("rst_req_ready", rd_req_ready, 1);
      chk("rst_rsp_valid", rd_rsp_valid, 0);
      chk("rst_rsp_pd", rd_rsp_pd, 0);
      chk("rst_cdt_err", cdt_err, 0);

      // Latency: handshake in cycle 0, first valid in cycle RSP_LAT+2.
      rd_rsp_ready = 1'b1;
      send_req(32'h1000, 3);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("lat_c%0d", c), rd_rsp_valid, 0);
      end
      @(negedge clk);
      chk("lat_c6", rd_rsp_valid, 1);
      tick();
      drain(50);
      chk("single_beats", hs_cnt, 2);

      send_req(32'h2000, 2);
      drain(50);
      chk("odd_beats", hs_cnt, 4);

      // Credit exhaustion: 64 beats requested, only 32 credits.
      do_reset();
      send_req(32'h8000, 127);
      repeat (150) tick();
      chk("cdt_stop_cnt", hs_cnt, 32);
      chk("cdt_stop_valid", rd_rsp_valid, 0);
      rd_cdt_lat_fifo_pop = 1'b1;
      tick();
      rd_cdt_lat_fifo_pop = 1'b0;
      repeat (20) tick();
      chk("cdt_one_more", hs_cnt, 33);
      rd_cdt_lat_fifo_pop = 1'b1;
      repeat (31) tick();
      rd_cdt_lat_fifo_pop = 1'b0;
      drain(200);
      chk("cdt_all", hs_cnt, 64);

      // Backpressure: ready toggles every cycle.
      do_reset();
      send_req(32'h3000, 9);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         rd_rsp_ready = ~rd_rsp_ready;
         tick();
      end
      chk("bp_drain", exp_q.size(), 0);
      chk("bp_beats", hs_cnt, 5);

      // FIFO full while the engine is stalled on an earlier burst.
      do_reset();
      rd_rsp_ready = 1'b0;
      send_req(32'h4000, 1);
      for (int i = 0; i < 50 && rd_rsp_valid !== 1'b1; i++) tick();
      chk("full_stall_valid", rd_rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         rd_req_pd = {15'(i), 32'h0, 32'h5000 + 32'(i * 256)};
         rd_req_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("full_ready%0d", i), rd_req_ready, (i < 4) ? 1 : 0);
         if (rd_req_ready) push_exp(32'h5000 + 32'(i * 256), i);
         if (i < 4) tick();
      end
      tick();
      rd_rsp_ready = 1'b1;
      begin
         logic got;
         got = 1'b0;
         for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (rd_req_ready) got = 1'b1;
         end
         chk("full_reopen", got, 1);
         if (got) push_exp(32'h5400, 4);
         tick();
         rd_req_valid = 1'b0;
      end
      drain(200);
      chk("full_beats", hs_cnt, 10);

      // Credit overflow sticks; reset mid-burst clears everything.
      do_reset();
      rd_cdt_lat_fifo_pop = 1'b1;
      tick();
      rd_cdt_lat_fifo_pop = 1'b0;
      @(negedge clk);
      chk("cdt_err_set", cdt_err, 1);
      repeat (5) tick();
      chk("cdt_err_sticky", cdt_err, 1);
      send_req(32'h6000, 7);
      for (int i = 0; i < 50 && hs_cnt < 1; i++) tick();
      chk("mid_started", hs_cnt, 1);
      rstn = 1'b0;
      exp_q.delete();
      tick();
      rstn = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", rd_rsp_valid, 0);
      chk("mid_rst_ready", rd_req_ready, 1);
      chk("mid_rst_err", cdt_err, 0);
      chk("mid_rst_pd", rd_rsp_pd, 0);
      hs0 = hs_cnt;
      repeat (20) tick();
      chk("mid_rst_no_beat", hs_cnt, hs0);
      chk("mid_rst_idle", rd_rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
